// File: rtl/smolproc_pkg.sv
// ============================================================================
// Module      : smolproc_pkg
// Description : Shared types and constants for the smolproc pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package smolproc_pkg;

    typedef enum logic [1:0] {
        DM_PASS  = 2'b00,
        DM_LOAD  = 2'b01,
        DM_STORE = 2'b10,
        DM_RSVD  = 2'b11
    } dm_ctrl_e;

    typedef enum logic [0:0] {
        PORT_IDLE = 1'b0,
        PORT_FULL = 1'b1
    } port_state_e;

    localparam logic [7:0] IO_OUT_ADDR_DEFAULT = 8'hFF;
    localparam logic [7:0] IO_IN_ADDR_DEFAULT  = 8'hFE;

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// Module      : data_ram
// Description : 256x8 data RAM, asynchronous read, synchronous write, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// Module      : memory_stage
// Description : Load/store/pass stage with data RAM and a stalling output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage
    import smolproc_pkg::*;
#(
    parameter logic [7:0] ADDR_IO_OUT = IO_OUT_ADDR_DEFAULT,
    parameter logic [7:0] ADDR_IO_IN  = IO_IN_ADDR_DEFAULT
) (
    input  logic       sig_clk,
    input  logic       sig_rst,
    input  logic [7:0] EX_data_result,
    input  logic [7:0] EX_data_reg,
    input  logic [1:0] EX_addr_reg,
    input  logic [1:0] EX_sig_ctrl_DM,
    input  logic       EX_sig_ctrl_RF,
    output logic [7:0] FW_RF_data_wb,
    output logic [1:0] FW_RF_addr_wb,
    output logic       FW_RF_sig_wb,
    output logic       HZ_sig_stall,
    output logic [7:0] IO_data_out,
    output logic       IO_sig_valid,
    input  logic       IO_sig_ready,
    input  logic [7:0] IO_data_in
);

    dm_ctrl_e    dm_ctrl;
    logic        is_load;
    logic        is_store;
    logic        hit_out;
    logic        hit_in;
    logic        port_store;
    logic        port_xfer;
    logic        port_accept;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  load_data;

    port_state_e port_state_q, port_state_d;
    logic [7:0]  io_data_q, io_data_d;
    logic [7:0]  wb_data_q, wb_data_d;
    logic [1:0]  wb_addr_q, wb_addr_d;
    logic        wb_en_q, wb_en_d;

    assign dm_ctrl  = dm_ctrl_e'(EX_sig_ctrl_DM);
    assign is_load  = (dm_ctrl == DM_LOAD);
    assign is_store = (dm_ctrl == DM_STORE);
    assign hit_out  = (EX_data_result == ADDR_IO_OUT);
    assign hit_in   = (EX_data_result == ADDR_IO_IN);

    assign port_store   = is_store && hit_out;
    assign IO_sig_valid = (port_state_q == PORT_FULL);
    assign port_xfer    = IO_sig_valid && IO_sig_ready;
    assign HZ_sig_stall = port_store && IO_sig_valid && !IO_sig_ready;
    assign port_accept  = port_store && !HZ_sig_stall;

    // The two port addresses shadow their RAM bytes, so those are never written.
    assign ram_we = is_store && !hit_out && !hit_in && !sig_rst;

    data_ram #(
        .DEPTH_LOG2 (8),
        .WIDTH      (8)
    ) u_data_ram (
        .clk_i   (sig_clk),
        .we_i    (ram_we),
        .addr_i  (EX_data_result),
        .wdata_i (EX_data_reg),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        load_data = ram_rdata;
        if (hit_in) begin
            load_data = IO_data_in;
        end else if (hit_out) begin
            load_data = io_data_q;
        end
    end

    always_comb begin
        port_state_d = port_state_q;
        io_data_d    = io_data_q;
        case (port_state_q)
            PORT_IDLE: if (port_accept) port_state_d = PORT_FULL;
            PORT_FULL: if (port_xfer && !port_accept) port_state_d = PORT_IDLE;
            default:   port_state_d = PORT_IDLE;
        endcase
        if (port_accept) begin
            io_data_d = EX_data_reg;
        end
    end

    always_comb begin
        wb_en_d   = EX_sig_ctrl_RF && !is_store && !HZ_sig_stall;
        wb_addr_d = EX_addr_reg;
        wb_data_d = is_load ? load_data : EX_data_result;
    end

    always_ff @(posedge sig_clk) begin
        if (sig_rst) begin
            port_state_q <= PORT_IDLE;
            io_data_q    <= 8'h00;
            wb_data_q    <= 8'h00;
            wb_addr_q    <= 2'b00;
            wb_en_q      <= 1'b0;
        end else begin
            port_state_q <= port_state_d;
            io_data_q    <= io_data_d;
            wb_data_q    <= wb_data_d;
            wb_addr_q    <= wb_addr_d;
            wb_en_q      <= wb_en_d;
        end
    end

    assign IO_data_out   = io_data_q;
    assign FW_RF_data_wb = wb_data_q;
    assign FW_RF_addr_wb = wb_addr_q;
    assign FW_RF_sig_wb  = wb_en_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed plus random checks of memory_stage against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    logic       sig_clk = 1'b0;
    logic       sig_rst = 1'b1;
    logic [7:0] EX_data_result = 8'h00;
    logic [7:0] EX_data_reg = 8'h00;
    logic [1:0] EX_addr_reg = 2'b00;
    logic [1:0] EX_sig_ctrl_DM = 2'b00;
    logic       EX_sig_ctrl_RF = 1'b0;
    logic [7:0] FW_RF_data_wb;
    logic [1:0] FW_RF_addr_wb;
    logic       FW_RF_sig_wb;
    logic       HZ_sig_stall;
    logic [7:0] IO_data_out;
    logic       IO_sig_valid;
    logic       IO_sig_ready = 1'b0;
    logic [7:0] IO_data_in = 8'h00;

    memory_stage dut (
        .sig_clk        (sig_clk),
        .sig_rst        (sig_rst),
        .EX_data_result (EX_data_result),
        .EX_data_reg    (EX_data_reg),
        .EX_addr_reg    (EX_addr_reg),
        .EX_sig_ctrl_DM (EX_sig_ctrl_DM),
        .EX_sig_ctrl_RF (EX_sig_ctrl_RF),
        .FW_RF_data_wb  (FW_RF_data_wb),
        .FW_RF_addr_wb  (FW_RF_addr_wb),
        .FW_RF_sig_wb   (FW_RF_sig_wb),
        .HZ_sig_stall   (HZ_sig_stall),
        .IO_data_out    (IO_data_out),
        .IO_sig_valid   (IO_sig_valid),
        .IO_sig_ready   (IO_sig_ready),
        .IO_data_in     (IO_data_in)
    );

    always #5 sig_clk = ~sig_clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: RAM image with a written-mask, port byte and flag.
    logic [7:0] m_ram [0:255];
    bit         m_known [0:255];
    bit         m_valid = 1'b0;
    logic [7:0] m_out = 8'h00;
    bit         e_wb_en = 1'b0;
    logic [1:0] e_wb_addr = 2'b00;
    logic [7:0] e_wb_data = 8'h00;
    bit         e_data_known = 1'b1;
    bit         exp_stall = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_ex(input logic [1:0] ctrl, input logic [7:0] res,
                          input logic [7:0] dat, input logic [1:0] rg, input logic rf);
        EX_sig_ctrl_DM = ctrl;
        EX_data_result = res;
        EX_data_reg    = dat;
        EX_addr_reg    = rg;
        EX_sig_ctrl_RF = rf;
    endtask

    // One clock: check stall before the edge, advance the model, check registers.
    task automatic tick();
        bit is_store;
        bit is_load;
        exp_stall = (EX_sig_ctrl_DM == 2'b10) && (EX_data_result == 8'hFF)
                    && m_valid && !IO_sig_ready;
        #1;
        if (!sig_rst) check("stall", {7'b0, HZ_sig_stall}, {7'b0, exp_stall});
        @(posedge sig_clk);
        is_store = (EX_sig_ctrl_DM == 2'b10);
        is_load  = (EX_sig_ctrl_DM == 2'b01);
        if (sig_rst) begin
            m_valid = 1'b0;
            m_out = 8'h00;
            e_wb_en = 1'b0;
            e_wb_addr = 2'b00;
            e_wb_data = 8'h00;
            e_data_known = 1'b1;
        end else begin
            e_wb_en = EX_sig_ctrl_RF && !is_store && !exp_stall;
            e_wb_addr = EX_addr_reg;
            e_data_known = 1'b1;
            if (is_load) begin
                if (EX_data_result == 8'hFE) e_wb_data = IO_data_in;
                else if (EX_data_result == 8'hFF) e_wb_data = m_out;
                else begin
                    e_wb_data = m_ram[EX_data_result];
                    e_data_known = m_known[EX_data_result];
                end
            end else begin
                e_wb_data = EX_data_result;
            end
            if (is_store && EX_data_result == 8'hFF) begin
                if (!exp_stall) begin
                    m_out = EX_data_reg;
                    m_valid = 1'b1;
                end
            end else begin
                if (m_valid && IO_sig_ready) m_valid = 1'b0;
                if (is_store && EX_data_result != 8'hFE) begin
                    m_ram[EX_data_result] = EX_data_reg;
                    m_known[EX_data_result] = 1'b1;
                end
            end
        end
        #1;
        check("wb_en", {7'b0, FW_RF_sig_wb}, {7'b0, e_wb_en});
        check("wb_addr", {6'b0, FW_RF_addr_wb}, {6'b0, e_wb_addr});
        if (e_wb_en && e_data_known) check("wb_data", FW_RF_data_wb, e_wb_data);
        check("io_valid", {7'b0, IO_sig_valid}, {7'b0, m_valid});
        check("io_data", IO_data_out, m_out);
        @(negedge sig_clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_ram[i] = 8'h00;
        end
        @(negedge sig_clk);
        sig_rst = 1'b1;
        tick();
        tick();
        sig_rst = 1'b0;

        // Pass
        set_ex(2'b00, 8'h3C, 8'h00, 2'd2, 1'b1);
        tick();
        check("pass_data", FW_RF_data_wb, 8'h3C);

        // Store then load back-to-back
        set_ex(2'b10, 8'h10, 8'hA5, 2'd1, 1'b1);
        tick();
        check("store_no_wb", {7'b0, FW_RF_sig_wb}, 8'h00);
        set_ex(2'b01, 8'h10, 8'h00, 2'd1, 1'b1);
        tick();
        check("load_ram", FW_RF_data_wb, 8'hA5);

        // Port store, then a blocked second store, then release
        IO_sig_ready = 1'b0;
        set_ex(2'b10, 8'hFF, 8'h11, 2'd0, 1'b0);
        tick();
        check("port_first", IO_data_out, 8'h11);
        set_ex(2'b10, 8'hFF, 8'h22, 2'd3, 1'b1);
        tick();
        tick();
        IO_sig_ready = 1'b1;
        tick();
        check("port_second", IO_data_out, 8'h22);
        IO_sig_ready = 1'b0;

        // Input port load; a store to the input address is discarded
        IO_data_in = 8'h5A;
        set_ex(2'b01, 8'hFE, 8'h00, 2'd0, 1'b1);
        tick();
        check("io_in_load", FW_RF_data_wb, 8'h5A);
        set_ex(2'b10, 8'hFE, 8'h77, 2'd0, 1'b1);
        tick();
        set_ex(2'b01, 8'hFE, 8'h00, 2'd0, 1'b1);
        tick();
        check("io_in_after_store", FW_RF_data_wb, 8'h5A);

        // Reserved control acts as pass
        set_ex(2'b11, 8'h09, 8'h00, 2'd3, 1'b1);
        tick();
        check("rsvd_pass", FW_RF_data_wb, 8'h09);

        // Reset in the middle of a stall
        set_ex(2'b10, 8'hFF, 8'h33, 2'd2, 1'b1);
        tick();
        check("stall_held", {7'b0, HZ_sig_stall}, 8'h01);
        sig_rst = 1'b1;
        tick();
        sig_rst = 1'b0;
        check("rst_valid", {7'b0, IO_sig_valid}, 8'h00);
        check("rst_wb", {7'b0, FW_RF_sig_wb}, 8'h00);
        set_ex(2'b00, 8'h00, 8'h00, 2'd0, 1'b0);
        tick();

        // Random traffic; stalled stores are held as upstream would
        for (int n = 0; n < 400; n++) begin
            if (!((EX_sig_ctrl_DM == 2'b10) && (EX_data_result == 8'hFF)
                  && m_valid && !IO_sig_ready)) begin
                logic [7:0] a;
                case ($urandom_range(0, 5))
                    0: a = 8'hFF;
                    1: a = 8'hFE;
                    default: a = 8'h20 + 8'($urandom_range(0, 3));
                endcase
                set_ex(2'($urandom_range(0, 3)), a, 8'($urandom),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            IO_sig_ready = ($urandom_range(0, 2) == 0);
            IO_data_in   = 8'($urandom);
            sig_rst      = ($urandom_range(0, 63) == 0);
            tick();
        end
        sig_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage. Consumes the registered ALU/address result, store data, destination register and DM/RF controls, and performs one of three operations: data-memory load, data-memory store, or pass-through. Produces the registered register-file writeback (also fed to the forwarding unit). Owns the 256×8 data RAM and a memory-mapped byte output port with a valid/ready handshake that can stall the pipeline.

## Interface
Parameters:
- ADDR_IO_OUT, 8'hFF, store-only output port address
- ADDR_IO_IN, 8'hFE, load-only input port address

Ports:
- sig_clk  in  1  clock; all state updates on posedge
- sig_rst  in  1  reset; synchronous, active-high
- EX_data_result  in  8  ALU result or effective address from execute
- EX_data_reg  in  8  store data (operand A) from execute
- EX_addr_reg  in  2  destination register index
- EX_sig_ctrl_DM  in  2  00 pass, 01 load, 10 store, 11 treated as pass
- EX_sig_ctrl_RF  in  1  register-file write requested
- FW_RF_data_wb  out  8  writeback data, registered
- FW_RF_addr_wb  out  2  writeback register index, registered
- FW_RF_sig_wb  out  1  writeback enable, registered
- HZ_sig_stall  out  1  freeze upstream stages this cycle (combinational)
- IO_data_out  out  8  output-port byte, registered
- IO_sig_valid  out  1  output-port byte pending
- IO_sig_ready  in  1  consumer accepts byte this cycle
- IO_data_in  in  8  input-port byte, sampled on load from ADDR_IO_IN

## Operation
- Address = EX_data_result for both load and store.
- Pass: FW_RF_data_wb <= EX_data_result.
- Load: address ADDR_IO_IN -> IO_data_in; ADDR_IO_OUT -> current IO_data_out; otherwise RAM[address] (combinational read).
- Store to a RAM address: RAM[address] <= EX_data_reg at the edge. No writeback.
- Store to ADDR_IO_IN: discarded, no effect.
- Store to ADDR_IO_OUT: if IO_sig_valid=0, or IO_sig_ready=1 this cycle, then IO_data_out <= EX_data_reg and IO_sig_valid <= 1. Otherwise HZ_sig_stall=1.
- RAM is not written at ADDR_IO_OUT or ADDR_IO_IN. Those two RAM bytes are unreachable.
- FW_RF_sig_wb <= EX_sig_ctrl_RF & (ctrl != store) & ~HZ_sig_stall. FW_RF_addr_wb <= EX_addr_reg.
- Output-port handshake: a transfer occurs on any edge where IO_sig_valid & IO_sig_ready. After a transfer, IO_sig_valid <= 0 unless a new port store is accepted in the same cycle, in which case it stays 1 with the new data.
- While IO_sig_valid=1, IO_data_out is held stable.
- Stall: HZ_sig_stall = store & address==ADDR_IO_OUT & IO_sig_valid & ~IO_sig_ready.
  - Upstream holds its EX_* outputs while stalled.
  - This stage inserts a bubble (FW_RF_sig_wb <= 0) and performs no RAM write.
  - The held store retries every cycle until accepted.
- Port state machine has two states. IDLE (valid=0) goes to FULL on an accepted port store. FULL goes to IDLE on a transfer with no new store, and stays FULL on a transfer plus a new store.

## Timing
- Latency: one cycle from EX_* inputs to FW_RF_* outputs. Store-to-RAM becomes visible to a load in the very next cycle (back-to-back store/load to the same address returns the new byte).
- HZ_sig_stall depends combinationally on EX_* inputs, IO_sig_valid and IO_sig_ready. There is no path from IO_sig_ready to IO_data_out within a cycle.
- Reset values: FW_RF_data_wb=0, FW_RF_addr_wb=0, FW_RF_sig_wb=0, IO_data_out=0, IO_sig_valid=0. HZ_sig_stall=0 once registers are reset. RAM contents are not reset.
- Reset asserted mid-stall: the pending port byte is dropped, valid is cleared, stall is released, and the held store is not performed during reset.
- While sig_rst=1, no RAM write and no port update occur.

## Structure
- Shared package smolproc_pkg holds:
  - DM control enum (DM_PASS, DM_LOAD, DM_STORE, DM_RSVD)
  - IO address constants as package defaults for the parameters
- Sub-module data_ram: 256×8, combinational read port, synchronous write port with write enable. No reset. Inferable as distributed RAM.
- Port handshake and stall logic stay in memory_stage.

## Test plan
- Reset, then pass ctrl=00, result=8'h3C, reg=2, RF=1 -> next cycle wb=1, addr=2, data=8'h3C.
- Store 8'hA5 to 8'h10, next cycle load 8'h10 into reg 1 -> wb data=8'hA5, and no wb during the store cycle.
- Store 8'h11 to 8'hFF with ready=0 -> valid=1, data=8'h11. Second store 8'h22 to 8'hFF with ready=0 -> stall=1 and wb=0 each cycle. Raise ready -> 8'h11 transfers, 8'h22 is latched, valid stays 1, stall drops.
- IO_data_in=8'h5A, load 8'hFE -> wb data=8'h5A. Then store 8'h77 to 8'hFE and load 8'hFE with IO_data_in=8'h5A -> still 8'h5A, and RAM is untouched.
- Store with RF=1 -> wb=0. Ctrl=11 with result=8'h09 -> behaves as pass, wb data=8'h09.
- Hold a stalled port store, then assert sig_rst one cycle -> valid=0, IO_data_out=0, stall=0, and all wb outputs are 0 the cycle after.
